ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
// Shares one 64x8 single-port RAM (write + registered read address, q = ram[addr_reg])
// between two requesters. Arbitration is round-robin, with a valid/ready request handshake.
// Accepted requests are issued to the RAM through a registered issue stage.
// Read data is returned on per-requester response ports.
// The block sits between two client engines and the RAM instance.
// PARAMETERS
// DATA_W  8  RAM word width
// ADDR_W  6  RAM address width (depth 2**ADDR_W)
// PORTS
// clk         in   1       clock; all state on rising edge
// rst         in   1       synchronous, active-high reset
// req0_valid  in   1       requester 0 has a request
// req0_we     in   1       1 = write, 0 = read
// req0_addr   in   ADDR_W  request address
// req0_wdata  in   DATA_W  write data (ignored for reads)
// req0_ready  out  1       request 0 accepted this cycle (combinational grant)
// rsp0_valid  out  1       one-cycle pulse: rsp0_rdata holds read data
// rsp0_rdata  out  DATA_W  read data for requester 0
// req1_*/rsp1_*  same as requester 0, for requester 1
// ram_data    out  DATA_W  to RAM data
// ram_addr    out  ADDR_W  to RAM addr
// ram_we      out  1       to RAM we
// ram_q       in   DATA_W  from RAM q
// BEHAVIOUR
// - Clocking: one clock (clk). Reset: synchronous, active-high (rst).
// - Grant (combinational):
//   - only one valid -> that requester is granted.
//   - both valid -> grant the requester not granted last; rr pointer 'last' is updated on every accept.
//   - reqN_ready = grant & reqN_valid & ~rst.
//   - Accept = valid & ready at a rising edge (edge E0). At most one accept per cycle; full throughput of 1 access/cycle.
// - Issue stage: registers we/addr/wdata/owner/valid at E0.
//   - ram_we = issue_valid & issue_we.
//   - ram_addr/ram_data hold their last value when idle.
//   - RAM writes and latches addr at E1.
// - Read capture:
//   - ram_q is valid in the cycle after E1 and is registered into rspN_rdata at E2 (N = owner).
//   - rspN_valid is high for exactly the cycle following E2. Read latency = 2 edges after acceptance.
//   - Writes produce no response.
// - No response back-pressure: the requester must take rsp in the pulse cycle.
// - rspN_rdata holds its last value when rspN_valid = 0.
// - Ordering: strict acceptance order, across both requesters.
//   - Write@E0 then read of the same addr@E0+1 returns the new data.
//   - Read and write to the same addr never collide, because only one access is issued per cycle.
// - Reset values:
//   - ram_we = 0, ram_addr = 0, ram_data = 0.
//   - rsp0/1_valid = 0, rsp0/1_rdata = 0.
//   - issue/capture valids = 0.
//   - last = 1, so requester 0 wins the first tie.
// - Reset mid-operation: in-flight issue and capture entries are dropped, with no rsp pulse after rst. RAM contents are untouched.
// - req fields may change freely while ready = 0; they are only sampled on accept.
// - Back-to-back alternation:
//   - With both valid every cycle, grants alternate 0,1,0,1...
//   - A lone requester is granted every cycle.
// TESTING
// - rst, then req0 write addr 5 = 8'hA5; next cycle req0 read addr 5 -> rsp0_valid 2 edges after read accept, rsp0_rdata = 8'hA5.
// - req0 and req1 both valid for 4 cycles (reads of addrs 1..4, pre-loaded 8'h11..8'h44) -> ready alternates 0,1,0,1 starting with 0; each rsp returns to its owner with the correct data, in order.
// - Only req1 valid for 3 reads -> req1_ready high all 3 cycles; 3 consecutive rsp1_valid pulses; rsp0_valid stays 0.
// - req1 write addr 63 = 8'hFF immediately followed by req0 read addr 63 -> rsp0_rdata = 8'hFF (address wrap/top boundary, ordering).
// - Accept a read, assert rst for 1 cycle at E1 -> no rsp pulse; after rst, first tie goes to req0; RAM still holds prior writes.
// - Write accept -> no rsp pulse; ram_we is high for exactly 1 cycle, with ram_addr/ram_data equal to the request.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bundles the two requester handshakes, their response ports and the RAM-side bus.
// The arbiter uses the slave view; the clients and the RAM sit on the master side.
interface ram_port_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  ram_q,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output ram_data, ram_addr, ram_we
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output ram_q,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  ram_data, ram_addr, ram_we
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters.
// One access is accepted per cycle; read data returns on the owner's response port two edges after accept.
module ram_port_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_port_arbiter_if.slave    bus
);
    logic              last_q, last_d;
    logic              gnt0, gnt1;
    logic              acc0, acc1;

    logic              iss_vld_p1_q, iss_vld_p1_d;
    logic              iss_we_p1_q, iss_we_p1_d;
    logic              iss_own_p1_q, iss_own_p1_d;
    logic [ADDR_W-1:0] iss_addr_p1_q, iss_addr_p1_d;
    logic [DATA_W-1:0] iss_data_p1_q, iss_data_p1_d;

    logic              cap_vld_p2_q, cap_vld_p2_d;
    logic              cap_own_p2_q, cap_own_p2_d;

    logic              rsp0_vld_q, rsp0_vld_d;
    logic              rsp1_vld_q, rsp1_vld_d;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;

    // A tie goes to whichever requester was not accepted last; nothing is accepted under reset.
    always_comb begin
        gnt1   = bus.req1_valid & (~bus.req0_valid | ~last_q);
        gnt0   = bus.req0_valid & ~gnt1;
        acc0   = gnt0 & ~rst;
        acc1   = gnt1 & ~rst;
        last_d = last_q;
        if (acc1) begin
            last_d = 1'b1;
        end else if (acc0) begin
            last_d = 1'b0;
        end
    end

    assign bus.req0_ready = acc0;
    assign bus.req1_ready = acc1;

    // Stage p1: issue register; address/data only reload on accept so the RAM bus holds when idle.
    always_comb begin
        iss_vld_p1_d  = acc0 | acc1;
        iss_we_p1_d   = iss_we_p1_q;
        iss_own_p1_d  = iss_own_p1_q;
        iss_addr_p1_d = iss_addr_p1_q;
        iss_data_p1_d = iss_data_p1_q;
        if (acc1) begin
            iss_we_p1_d   = bus.req1_we;
            iss_own_p1_d  = 1'b1;
            iss_addr_p1_d = bus.req1_addr;
            iss_data_p1_d = bus.req1_wdata;
        end else if (acc0) begin
            iss_we_p1_d   = bus.req0_we;
            iss_own_p1_d  = 1'b0;
            iss_addr_p1_d = bus.req0_addr;
            iss_data_p1_d = bus.req0_wdata;
        end
    end

    assign bus.ram_we   = iss_vld_p1_q & iss_we_p1_q;
    assign bus.ram_addr = iss_addr_p1_q;
    assign bus.ram_data = iss_data_p1_q;

    // Stage p2: the RAM has latched a read address; remember who owns the data arriving on ram_q.
    always_comb begin
        cap_vld_p2_d = iss_vld_p1_q & ~iss_we_p1_q;
        cap_own_p2_d = iss_own_p1_q;
    end

    // Stage p3: register ram_q into the owner's response port for a one-cycle pulse.
    always_comb begin
        rsp0_vld_d   = cap_vld_p2_q & ~cap_own_p2_q;
        rsp1_vld_d   = cap_vld_p2_q &  cap_own_p2_q;
        rsp0_rdata_d = rsp0_vld_d ? bus.ram_q : rsp0_rdata_q;
        rsp1_rdata_d = rsp1_vld_d ? bus.ram_q : rsp1_rdata_q;
    end

    assign bus.rsp0_valid = rsp0_vld_q;
    assign bus.rsp1_valid = rsp1_vld_q;
    assign bus.rsp0_rdata = rsp0_rdata_q;
    assign bus.rsp1_rdata = rsp1_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q        <= 1'b1;
            iss_vld_p1_q  <= 1'b0;
            iss_we_p1_q   <= 1'b0;
            iss_own_p1_q  <= 1'b0;
            iss_addr_p1_q <= '0;
            iss_data_p1_q <= '0;
            cap_vld_p2_q  <= 1'b0;
            cap_own_p2_q  <= 1'b0;
            rsp0_vld_q    <= 1'b0;
            rsp1_vld_q    <= 1'b0;
            rsp0_rdata_q  <= '0;
            rsp1_rdata_q  <= '0;
        end else begin
            last_q        <= last_d;
            iss_vld_p1_q  <= iss_vld_p1_d;
            iss_we_p1_q   <= iss_we_p1_d;
            iss_own_p1_q  <= iss_own_p1_d;
            iss_addr_p1_q <= iss_addr_p1_d;
            iss_data_p1_q <= iss_data_p1_d;
            cap_vld_p2_q  <= cap_vld_p2_d;
            cap_own_p2_q  <= cap_own_p2_d;
            rsp0_vld_q    <= rsp0_vld_d;
            rsp1_vld_q    <= rsp1_vld_d;
            rsp0_rdata_q  <= rsp0_rdata_d;
            rsp1_rdata_q  <= rsp1_rdata_d;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a vector table for arbitration/data flow plus
// hand-written sequences for reset mid-flight and write-bus timing. Includes a 64x8 RAM model.
module tb_ram_port_arbiter;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    ram_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ram_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Single-port RAM: write plus registered read address, q = mem[addr_reg].
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] mem_areg = '0;
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
        mem_areg <= bus.ram_addr;
    end
    assign bus.ram_q = mem[mem_areg];

    typedef struct {
        logic        v0, we0;
        logic [5:0]  a0;
        logic [7:0]  d0;
        logic        v1, we1;
        logic [5:0]  a1;
        logic [7:0]  d1;
        logic [20:0] exp;   // {rdy0, rdy1, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, ram_we}
    } vec_t;

    vec_t tbl [30];

    function automatic vec_t mk(logic v0, logic we0, logic [5:0] a0, logic [7:0] d0,
                                logic v1, logic we1, logic [5:0] a1, logic [7:0] d1,
                                logic r0, logic r1, logic rv0, logic rv1,
                                logic [7:0] rd0, logic [7:0] rd1, logic we);
        vec_t v;
        v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
        v.exp = {r0, r1, rv0, rv1, rd0, rd1, we};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic we0, input logic [5:0] a0, input logic [7:0] d0,
                         input logic v1, input logic we1, input logic [5:0] a1, input logic [7:0] d1);
        bus.req0_valid = v0; bus.req0_we = we0; bus.req0_addr = a0; bus.req0_wdata = d0;
        bus.req1_valid = v1; bus.req1_we = we1; bus.req1_addr = a1; bus.req1_wdata = d1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [20:0] act;

        tbl[0]  = mk(1,1, 5,8'hA5, 0,0, 0,8'h00, 1,0,0,0, 8'h00,8'h00,0);
        tbl[1]  = mk(1,0, 5,8'h00, 0,0, 0,8'h00, 1,0,0,0, 8'h00,8'h00,1);
        tbl[2]  = mk(0,0, 0,8'h00, 0,0, 0,8'h00, 0,0,0,0, 8'h00,8'h00,0);
        tbl[3]  = mk(0,0, 0,8'h00, 0,0, 0,8'h00, 0,0,0,0, 8'h00,8'h00,0);
        tbl[4]  = mk(0,0, 0,8'h00, 0,0, 0,8'h00, 0,0,1,0, 8'hA5,8'h00,0);
        tbl[5]  = mk(0,0, 0,8'h00, 0,0, 0,8'h00, 0,0,0,0, 8'hA5,8'h00,0);
        tbl[6]  = mk(0,0, 0,8'h00, 1,1, 1,8'h11, 0,1,0,0, 8'hA5,8'h00,0);
        tbl[7]  = mk(0,0, 0,8'h00, 1,1, 2,8'h22, 0,1,0,0, 8'hA5,8'h00,1);
        tbl[8]  = mk(0,0, 0,8'h00, 1,1, 3,8'h33, 0,1,0,0, 8'hA5,8'h00,1);
        tbl[9]  = mk(0,0, 0,8'h00, 1,1, 4,8'h44, 0,1,0,0, 8'hA5,8'h00,1);
        tbl[10] = mk(0,0, 0,8'h00, 0,0, 0,8'h00, 0,0,0,0, 8'hA5,8'h00,1);
        tbl[11] = mk(1,0, 1,8'h00, 1,0, 5,8'h00, 1,0,0,0, 8'hA5,8'h00,0);
        tbl[12] = mk(1,0, 5,8'h00, 1,0, 2,8'h00, 0,1,0,0, 8'hA5,8'h00,0);
        tbl[13] = mk(1,0, 3,8'h00, 1,0, 5,8'h00, 1,0,0,0, 8'hA5,8'h00,0);
        tbl[14] = mk(1,0, 5,8'h00, 1,0, 4,8'h00, 0,1,1,0, 8'h11,8'h00,0);
        tbl[15] = mk(0,0, 0,8'h00, 0,0, 0,8'h00, 0,0,0,1, 8'h11,8'h22,0);
        tbl[16] = mk(0,0, 0,8'h00, 0,0, 0,8'h00, 0,0,1,0, 8'h33,8'h22,0);
        tbl[17] = mk(0,0, 0,8'h00, 0,0, 0,8'h00, 0,0,0,1, 8'h33,8'h44,0);
        tbl[18] = mk(0,0, 0,8'h00, 1,0, 1,8'h00, 0,1,0,0, 8'h33,8'h44,0);
        tbl[19] = mk(0,0, 0,8'h00, 1,0, 2,8'h00, 0,1,0,0, 8'h33,8'h44,0);
        tbl[20] = mk(0,0, 0,8'h00, 1,0, 3,8'h00, 0,1,0,0, 8'h33,8'h44,0);
        tbl[21] = mk(0,0, 0,8'h00, 0,0, 0,8'h00, 0,0,0,1, 8'h33,8'h11,0);
        tbl[22] = mk(0,0, 0,8'h00, 0,0, 0,8'h00, 0,0,0,1, 8'h33,8'h22,0);
        tbl[23] = mk(0,0, 0,8'h00, 0,0, 0,8'h00, 0,0,0,1, 8'h33,8'h33,0);
        tbl[24] = mk(0,0, 0,8'h00, 1,1,63,8'hFF, 0,1,0,0, 8'h33,8'h33,0);
        tbl[25] = mk(1,0,63,8'h00, 0,0, 0,8'h00, 1,0,0,0, 8'h33,8'h33,1);
        tbl[26] = mk(0,0, 0,8'h00, 0,0, 0,8'h00, 0,0,0,0, 8'h33,8'h33,0);
        tbl[27] = mk(0,0, 0,8'h00, 0,0, 0,8'h00, 0,0,0,0, 8'h33,8'h33,0);
        tbl[28] = mk(0,0, 0,8'h00, 0,0, 0,8'h00, 0,0,1,0, 8'hFF,8'h33,0);
        tbl[29] = mk(0,0, 0,8'h00, 0,0, 0,8'h00, 0,0,0,0, 8'hFF,8'h33,0);

        // Reset: outputs cleared, no ready even with both requesters valid.
        rst = 1'b1;
        drive(1, 0, 7, 8'h00, 1, 0, 8, 8'h00);
        step();
        step();
        @(negedge clk);
        chk("rst_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        chk("rst_rsp", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata, bus.rsp1_rdata}, 32'd0);
        chk("rst_ram", {bus.ram_we, bus.ram_addr, bus.ram_data}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        step();

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].v0, tbl[i].we0, tbl[i].a0, tbl[i].d0,
                  tbl[i].v1, tbl[i].we1, tbl[i].a1, tbl[i].d1);
            @(negedge clk);
            act = {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
                   bus.rsp0_rdata, bus.rsp1_rdata, bus.ram_we};
            chk($sformatf("vec%0d", i), {11'd0, act}, {11'd0, tbl[i].exp});
            step();
        end

        // Read accepted, then reset at the following edge: the read must vanish.
        drive(1, 0, 5, 8'h00, 0, 0, 0, 8'h00);
        @(negedge clk);
        chk("mid_acc", {31'd0, bus.req0_ready}, 32'd1);
        step();
        rst = 1'b1;
        drive(1, 0, 1, 8'h00, 1, 0, 2, 8'h00);
        @(negedge clk);
        chk("mid_rst_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        step();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("post_rst_rsp", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata, bus.rsp1_rdata}, 32'd0);
        chk("post_rst_ram", {bus.ram_we, bus.ram_addr, bus.ram_data}, 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("no_pulse%0d", i), {30'd0, bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
            step();
        end
        drive(1, 0, 1, 8'h00, 1, 0, 2, 8'h00);
        @(negedge clk);
        chk("post_rst_tie", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd2);
        step();
        idle();
        step();
        step();
        @(negedge clk);
        chk("post_rst_data", {23'd0, bus.rsp0_valid, bus.rsp0_rdata}, {23'd0, 1'b1, 8'h11});
        step();

        // Write accept: exactly one ram_we cycle carrying the request, then the bus holds.
        drive(0, 0, 0, 8'h00, 1, 1, 9, 8'h5A);
        @(negedge clk);
        chk("wr_acc", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd1);
        step();
        idle();
        @(negedge clk);
        chk("wr_bus", {17'd0, bus.ram_we, bus.ram_addr, bus.ram_data}, {17'd0, 1'b1, 6'd9, 8'h5A});
        step();
        @(negedge clk);
        chk("wr_hold", {17'd0, bus.ram_we, bus.ram_addr, bus.ram_data}, {17'd0, 1'b0, 6'd9, 8'h5A});
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("wr_no_rsp%0d", i), {30'd0, bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
            step();
        end
        drive(1, 0, 9, 8'h00, 0, 0, 0, 8'h00);
        step();
        idle();
        step();
        step();
        @(negedge clk);
        chk("wr_readback", {23'd0, bus.rsp0_valid, bus.rsp0_rdata}, {23'd0, 1'b1, 8'h5A});
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
